// File: rtl/stack_drop_ctrl.sv
// Single-cell falling-block stacking game on a COLS x ROWS well.
// Turns pad edges and frame ticks into piece motion, column heights and a score.
module stack_drop_ctrl #(
  parameter int COLS        = 10,
  parameter int ROWS        = 15,
  parameter int SPAWN_COL   = 4,
  parameter int GRAV_FRAMES = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                new_piece,
  input  logic [1:0]          controls,
  output logic [3:0]          piece_x,
  output logic [3:0]          piece_y,
  output logic                piece_active,
  output logic [COLS*4-1:0]   heights,
  output logic [7:0]          score,
  output logic                landed,
  output logic                game_over
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPAWN = 3'd1;
  localparam logic [2:0] S_FALL  = 3'd2;
  localparam logic [2:0] S_LAND  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int            CW        = (GRAV_FRAMES > 1) ? $clog2(GRAV_FRAMES) : 1;
  localparam logic [CW-1:0] GRAV_LAST = CW'(GRAV_FRAMES - 1);
  localparam logic [4:0]    ROWS5     = 5'(ROWS);
  localparam logic [3:0]    SPAWN4    = 4'(SPAWN_COL);
  localparam logic [3:0]    LAST_COL  = 4'(COLS - 1);

  logic [2:0]    state_reg;
  logic [3:0]    x_reg, y_reg;
  logic [3:0]    hgt_reg [COLS];
  logic [7:0]    score_reg;
  logic          active_reg, landed_reg, over_reg, pend_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    ctrl_q_reg;
  logic          np_q_reg;

  logic       left_edge, right_edge, np_edge, left_only, right_only;
  logic [3:0] h_cur, h_left, h_right, h_spawn, x_next;
  logic       due, step_req, move_ok, down_free;

  // Row r of a column with stack height h is free while r lies above the stack.
  function automatic logic cell_free(input logic [3:0] h, input logic [3:0] r);
    return {1'b0, r} < (ROWS5 - {1'b0, h});
  endfunction

  assign left_edge  = controls[1] & ~ctrl_q_reg[1];
  assign right_edge = controls[0] & ~ctrl_q_reg[0];
  assign np_edge    = new_piece & ~np_q_reg;
  assign left_only  = left_edge & ~right_edge;
  assign right_only = right_edge & ~left_edge;

  always_comb begin
    h_cur   = '0;
    h_left  = '0;
    h_right = '0;
    for (int c = 0; c < COLS; c++) begin
      if (x_reg == 4'(c))            h_cur   = hgt_reg[c];
      if (x_reg == 4'(c + 1))        h_left  = hgt_reg[c];
      if (x_reg + 4'd1 == 4'(c))     h_right = hgt_reg[c];
    end
  end

  assign h_spawn   = hgt_reg[SPAWN_COL];
  assign due       = frame_tick && (cnt_reg == GRAV_LAST);
  assign step_req  = due || pend_reg;
  assign move_ok   = (left_only  && (x_reg != 4'd0)    && cell_free(h_left,  y_reg)) ||
                     (right_only && (x_reg <  LAST_COL) && cell_free(h_right, y_reg));
  assign x_next    = left_only ? x_reg - 4'd1 : x_reg + 4'd1;
  // The bottom row is covered too: y+1 == ROWS is never "free" for an empty column.
  assign down_free = cell_free(h_cur, y_reg + 4'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      x_reg      <= SPAWN4;
      y_reg      <= '0;
      score_reg  <= '0;
      active_reg <= 1'b0;
      landed_reg <= 1'b0;
      over_reg   <= 1'b0;
      pend_reg   <= 1'b0;
      cnt_reg    <= '0;
      ctrl_q_reg <= '0;
      np_q_reg   <= 1'b0;
    end else begin
      ctrl_q_reg <= controls;
      np_q_reg   <= new_piece;
      landed_reg <= 1'b0;
      case (state_reg)
        S_IDLE: if (np_edge) state_reg <= S_SPAWN;
        S_SPAWN: begin
          x_reg    <= SPAWN4;
          y_reg    <= '0;
          cnt_reg  <= '0;
          pend_reg <= 1'b0;
          if ({1'b0, h_spawn} == ROWS5) begin
            state_reg <= S_OVER;
            over_reg  <= 1'b1;
          end else begin
            state_reg  <= S_FALL;
            active_reg <= 1'b1;
          end
        end
        S_FALL: begin
          if (frame_tick) cnt_reg <= due ? '0 : cnt_reg + CW'(1);
          if (move_ok) x_reg <= x_next;
          // A move wins the cycle; the step waits one cycle and then uses the new column.
          if (step_req && move_ok) begin
            pend_reg <= 1'b1;
          end else if (step_req) begin
            pend_reg <= 1'b0;
            if (down_free) begin
              y_reg <= y_reg + 4'd1;
            end else begin
              state_reg  <= S_LAND;
              active_reg <= 1'b0;
              landed_reg <= 1'b1;
            end
          end
        end
        S_LAND: begin
          if (score_reg != 8'hFF) score_reg <= score_reg + 8'd1;
          state_reg <= S_IDLE;
        end
        S_OVER: state_reg <= S_OVER;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    always_ff @(posedge clk) begin
      if (!rst) begin
        hgt_reg[gi] <= '0;
      end else if (state_reg == S_LAND && x_reg == 4'(gi)) begin
        hgt_reg[gi] <= hgt_reg[gi] + 4'd1;
      end
    end
    assign heights[4*gi +: 4] = hgt_reg[gi];
  end

  assign piece_x      = x_reg;
  assign piece_y      = y_reg;
  assign piece_active = active_reg;
  assign score        = score_reg;
  assign landed       = landed_reg;
  assign game_over    = over_reg;

endmodule

// File: tb/tb_stack_drop_ctrl.sv
// Directed bench for stack_drop_ctrl: a cell-grid game model checked every cycle,
// plus hand-computed expectations along the test plan.
module tb_stack_drop_ctrl;
  localparam int COLS = 10;
  localparam int ROWS = 15;
  localparam int SPAWN = 4;
  localparam int GRAV = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic new_piece = 1'b0;
  logic [1:0] controls = 2'b00;
  logic [3:0] piece_x, piece_y;
  logic piece_active, landed, game_over;
  logic [COLS*4-1:0] heights;
  logic [7:0] score;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  stack_drop_ctrl #(.COLS(COLS), .ROWS(ROWS), .SPAWN_COL(SPAWN), .GRAV_FRAMES(GRAV)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .new_piece(new_piece),
    .controls(controls), .piece_x(piece_x), .piece_y(piece_y),
    .piece_active(piece_active), .heights(heights), .score(score),
    .landed(landed), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Game model: a grid of settled cells, the falling piece and a phase.
  localparam int P_WAIT = 0, P_APPEAR = 1, P_DROP = 2, P_SETTLE = 3, P_DEAD = 4;
  bit grid [COLS][ROWS];
  int m_phase, m_x, m_y, m_tick, m_score;
  bit m_pend, m_act, m_land, m_over;
  logic [1:0] m_pc;
  logic m_pn;

  function automatic int col_height(input int c);
    int n = 0;
    for (int r = 0; r < ROWS; r++) if (grid[c][r]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    bit le, re, moved, want;
    int dx, nx;
    started = 1'b1;
    if (!rst) begin
      for (int c = 0; c < COLS; c++) for (int r = 0; r < ROWS; r++) grid[c][r] = 1'b0;
      m_phase = P_WAIT; m_x = SPAWN; m_y = 0; m_tick = 0; m_score = 0;
      m_pend = 0; m_act = 0; m_land = 0; m_over = 0; m_pc = 2'b00; m_pn = 1'b0;
    end else begin
      le = controls[1] && !m_pc[1];
      re = controls[0] && !m_pc[0];
      m_land = 0;
      case (m_phase)
        P_WAIT: if (new_piece && !m_pn) m_phase = P_APPEAR;
        P_APPEAR: begin
          m_x = SPAWN; m_y = 0; m_tick = 0; m_pend = 0;
          if (grid[SPAWN][0]) begin m_phase = P_DEAD; m_over = 1; end
          else begin m_phase = P_DROP; m_act = 1; end
        end
        P_DROP: begin
          dx = (le && !re) ? -1 : ((re && !le) ? 1 : 0);
          moved = 0;
          if (dx != 0) begin
            nx = m_x + dx;
            if (nx >= 0 && nx < COLS && !grid[nx][m_y]) begin m_x = nx; moved = 1; end
          end
          want = m_pend;
          if (frame_tick) begin
            if (m_tick == GRAV - 1) begin want = 1; m_tick = 0; end
            else m_tick++;
          end
          if (want && moved) m_pend = 1;
          else if (want) begin
            m_pend = 0;
            if (m_y + 1 < ROWS && !grid[m_x][m_y + 1]) m_y++;
            else begin m_phase = P_SETTLE; m_act = 0; m_land = 1; end
          end
        end
        P_SETTLE: begin
          grid[m_x][m_y] = 1'b1;
          if (m_score < 255) m_score++;
          m_phase = P_WAIT;
        end
        default: ;
      endcase
      m_pc = controls;
      m_pn = new_piece;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("piece_x", int'(piece_x), m_x);
      check("piece_y", int'(piece_y), m_y);
      check("piece_active", int'(piece_active), int'(m_act));
      check("landed", int'(landed), int'(m_land));
      check("game_over", int'(game_over), int'(m_over));
      check("score", int'(score), m_score);
      for (int c = 0; c < COLS; c++)
        check($sformatf("heights[%0d]", c), int'(heights[4*c +: 4]), col_height(c));
    end
  end

  function automatic int hcol(input int c);
    return int'(heights[4*c +: 4]);
  endfunction

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic press(input logic [1:0] b);
    @(negedge clk) controls = b;
    @(negedge clk) controls = 2'b00;
    $display("press %b -> x=%0d y=%0d", b, piece_x, piece_y);
  endtask

  task automatic pulse_np();
    @(negedge clk) new_piece = 1'b1;
    @(negedge clk) new_piece = 1'b0;
  endtask

  task automatic spawn();
    pulse_np();
    for (int k = 0; k < 3 && !piece_active; k++) @(negedge clk);
    check("spawn_active", int'(piece_active), 1);
    $display("spawn -> x=%0d y=%0d", piece_x, piece_y);
  endtask

  task automatic drop_land();
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = landed;
    end
    check("land_within_bound", int'(seen), 1);
    @(negedge clk);
    $display("landed -> col=%0d score=%0d", piece_x, score);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_heights", (heights == '0) ? 1 : 0, 1);
    check("rst_score", int'(score), 0);
    check("rst_x", int'(piece_x), 4);
    check("rst_active", int'(piece_active), 0);
    rst = 1'b1;

    // Spawn and free fall in an empty well.
    pulse_np();
    for (int k = 0; k < 3 && !piece_active; k++) @(negedge clk);
    check("t1_active", int'(piece_active), 1);
    check("t1_x", int'(piece_x), 4);
    check("t1_y", int'(piece_y), 0);
    repeat (28) tick();
    check("t2_y14", int'(piece_y), 14);
    tick();
    check("t2_no_land_yet", int'(landed), 0);
    tick();
    check("t2_landed", int'(landed), 1);
    @(negedge clk);
    check("t2_h4", hcol(4), 1);
    check("t2_score", int'(score), 1);

    // Lateral limits and simultaneous presses.
    spawn();
    repeat (4) press(2'b10);
    check("t3_x0", int'(piece_x), 0);
    press(2'b10);
    check("t3_wall", int'(piece_x), 0);
    repeat (3) press(2'b01);
    check("t3_x3", int'(piece_x), 3);
    press(2'b11);
    check("t3_both", int'(piece_x), 3);
    drop_land();
    check("t3_h3", hcol(3), 1);

    // Build column 3 to height 5.
    repeat (4) begin
      spawn();
      press(2'b10);
      drop_land();
    end
    check("t4_h3", hcol(3), 5);
    check("t4_score", int'(score), 6);

    // Left blocked by the column-3 stack at row 12.
    spawn();
    repeat (24) tick();
    check("t4_y12", int'(piece_y), 12);
    press(2'b10);
    check("t4_blocked", int'(piece_x), 4);
    drop_land();
    check("t4_h4", hcol(4), 2);

    // Lateral move coincident with a due step.
    spawn();
    tick();
    @(negedge clk) begin frame_tick = 1'b1; controls = 2'b01; end
    @(negedge clk) begin frame_tick = 1'b0; controls = 2'b00; end
    check("t5_x_moved", int'(piece_x), 5);
    check("t5_y_held", int'(piece_y), 0);
    @(negedge clk);
    check("t5_y_late", int'(piece_y), 1);
    tick();
    check("t5_cnt_restart", int'(piece_y), 1);
    tick();
    check("t5_next_step", int'(piece_y), 2);
    drop_land();
    check("t5_h5", hcol(5), 1);

    // Fill column 4, then game over.
    repeat (13) begin
      spawn();
      drop_land();
    end
    check("t6_h4_full", hcol(4), 15);
    check("t6_score", int'(score), 21);
    pulse_np();
    @(negedge clk);
    check("t6_over", int'(game_over), 1);
    check("t6_inactive", int'(piece_active), 0);
    press(2'b10);
    pulse_np();
    tick();
    tick();
    check("t6_still_over", int'(game_over), 1);
    check("t6_score_frozen", int'(score), 21);
    check("t6_x_frozen", int'(piece_x), 4);

    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("t7_over_cleared", int'(game_over), 0);
    check("t7_heights", (heights == '0) ? 1 : 0, 1);
    check("t7_score", int'(score), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end
endmodule
